// File: rtl/imem_arb64.sv
// Two-master arbiter for the 64-bit instruction-memory port.
// Define IMEM_ARB_RR_EN for round-robin; default is fixed priority m0 > m1.
module imem_arb64 #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [63:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [63:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [63:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o,
  output logic        proto_err_o
);

  localparam int unsigned PtrW =
    (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic            owner_q [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lock_q, lock_d;
  logic            sel_q, sel_d;
  logic            perr_q, perr_d;

  logic full, win, sel, push, pop, head;

  assign full = (cnt_q == CntMax);

`ifdef IMEM_ARB_RR_EN
  logic last_q, last_d;

  // Round-robin: on contention, favour the master not granted last.
  always_comb begin
    win = 1'b0;
    if (m0_req_i && m1_req_i) win = ~last_q;
    else if (m1_req_i)        win = 1'b1;
    last_d = last_q;
    if (push) last_d = sel;
  end

  // Round-robin history; m0 wins the first contention after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`else
  // Fixed priority: m0 always beats m1.
  always_comb begin
    win = 1'b0;
    if (!m0_req_i && m1_req_i) win = 1'b1;
  end
`endif

  assign sel  = lock_q ? sel_q : win;
  assign instr_req_o  = ~full & (lock_q | m0_req_i | m1_req_i);
  assign instr_addr_o = sel ? m1_addr_i : m0_addr_i;
  assign push = instr_req_o & instr_gnt_i;
  assign m0_gnt_o = push & ~sel;
  assign m1_gnt_o = push & sel;

  assign head = owner_q[rptr_q];
  assign pop  = instr_rvalid_i & (cnt_q != '0);

  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;
  assign m0_err_o    = pop & ~head & instr_err_i;
  assign m1_err_o    = pop & head & instr_err_i;
  assign m0_rdata_o  = instr_rdata_i;
  assign m1_rdata_o  = instr_rdata_i;

  assign busy_o      = instr_req_o | (cnt_q != '0);
  assign proto_err_o = perr_q;

  // Next-state for lock, owner pointers, count and sticky error.
  always_comb begin
    lock_d = instr_req_o & ~instr_gnt_i;
    sel_d  = sel;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    perr_d = perr_q | (instr_rvalid_i & (cnt_q == '0));
    if (push) begin
      wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
      sel_q  <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
      sel_q  <= sel_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      perr_q <= perr_d;
    end
  end

  // Owner FIFO storage: records who issued each granted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxOutstanding; i++) owner_q[i] <= 1'b0;
    end else if (push) begin
      owner_q[wptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_imem_arb64.sv
// Directed self-checking bench for imem_arb64.
// Expectations follow IMEM_ARB_RR_EN when it is defined.
module tb_imem_arb64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [63:0] m0_rdata, m1_rdata;
  logic        req, gnt, rvalid, err;
  logic [31:0] addr;
  logic [63:0] rdata;
  logic        busy, perr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_arb64 #(.MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .instr_req_o(req), .instr_addr_o(addr),
    .instr_gnt_i(gnt), .instr_rvalid_i(rvalid),
    .instr_rdata_i(rdata), .instr_err_i(err),
    .busy_o(busy), .proto_err_o(perr)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic e0, e1;

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m1_req = 0;
    m0_addr = '0; m1_addr = '0;
    gnt = 0; rvalid = 0; err = 0; rdata = '0;
    #2;
    chk("rst_req", req, 0);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
    chk("rst_rv", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", perr, 0);
    tick(); rst_n = 1'b1; tick();

    // 1: single m0 fetch
    m0_req = 1; m0_addr = 32'h1000; gnt = 1; settle();
    chk("t1_req", req, 1);
    chk("t1_addr", addr, 32'h1000);
    chk("t1_g0", m0_gnt, 1);
    chk("t1_g1", m1_gnt, 0);
    tick();
    m0_req = 0; gnt = 0; rvalid = 1;
    rdata = 64'hDEADBEEF_01234567; settle();
    chk("t1_rv0", m0_rvalid, 1);
    chk("t1_rd0", m0_rdata, 64'hDEADBEEF_01234567);
    chk("t1_rv1", m1_rvalid, 0);
    tick(); rvalid = 0; settle();
    chk("t1_busy", busy, 0);

    // 2: held selection while ungranted
    m0_req = 1; m0_addr = 32'h2000; settle();
    chk("t2_a0", addr, 32'h2000);
    chk("t2_g0", m0_gnt, 0);
    tick(); m1_req = 1; m1_addr = 32'h3000; settle();
    chk("t2_a1", addr, 32'h2000);
    chk("t2_g1", m1_gnt, 0);
    tick(); settle();
    chk("t2_a2", addr, 32'h2000);
    tick(); gnt = 1; settle();
    chk("t2_g0b", m0_gnt, 1);
    chk("t2_g1b", m1_gnt, 0);
    tick(); m0_req = 0; settle();
    chk("t2_a3", addr, 32'h3000);
    chk("t2_g1c", m1_gnt, 1);
    tick(); m1_req = 0; gnt = 0; rvalid = 1; err = 1; settle();
    chk("t2_rv0", m0_rvalid, 1);
    chk("t2_er0", m0_err, 1);
    chk("t2_er1", m1_err, 0);
    tick(); err = 0; settle();
    chk("t2_rv1", m1_rvalid, 1);
    chk("t2_rv0b", m0_rvalid, 0);
    tick(); rvalid = 0; settle();
    chk("t2_busy", busy, 0);

    // 3: capacity limit at two outstanding
    m0_req = 1; m0_addr = 32'h4000; gnt = 1;
    tick(); tick();
    m0_req = 0; m1_req = 1; settle();
    chk("t3_full_req", req, 0);
    chk("t3_full_g1", m1_gnt, 0);
    chk("t3_full_busy", busy, 1);
    tick(); rvalid = 1; settle();
    chk("t3_nocredit", req, 0);
    chk("t3_rv0a", m0_rvalid, 1);
    tick(); rvalid = 0; settle();
    chk("t3_req", req, 1);
    chk("t3_g1", m1_gnt, 1);
    tick(); m1_req = 0; gnt = 0; rvalid = 1; settle();
    chk("t3_rv0b", m0_rvalid, 1);
    tick(); settle();
    chk("t3_rv1", m1_rvalid, 1);
    chk("t3_rv0c", m0_rvalid, 0);
    tick(); rvalid = 0; settle();
    chk("t3_busy", busy, 0);

    // 4: continuous contention
    m0_req = 1; m1_req = 1; gnt = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
`ifdef IMEM_ARB_RR_EN
      e0 = (i % 2 == 0);
`else
      e0 = 1'b1;
`endif
      e1 = ~e0;
      chk("t4_g0", m0_gnt, e0);
      chk("t4_g1", m1_gnt, e1);
      tick(); rvalid = 1;
    end
    m0_req = 0; m1_req = 0; gnt = 0; settle();
    chk("t4_last", {m0_rvalid, m1_rvalid}, {e0, e1});
    tick(); rvalid = 0; settle();
    chk("t4_busy", busy, 0);

    // 6: push and pop in the same cycle
    m0_req = 1; gnt = 1;
    tick(); m0_req = 0; m1_req = 1; rvalid = 1; settle();
    chk("t6_rv0", m0_rvalid, 1);
    chk("t6_g1", m1_gnt, 1);
    chk("t6_rv1", m1_rvalid, 0);
    tick(); m1_req = 0; gnt = 0; rvalid = 0; settle();
    chk("t6_busy1", busy, 1);
    rvalid = 1; settle();
    chk("t6_head", m1_rvalid, 1);
    tick(); rvalid = 0; settle();
    chk("t6_busy0", busy, 0);

    // 5: stray response with empty FIFO
    rvalid = 1; settle();
    chk("t5_rv", {m0_rvalid, m1_rvalid}, 0);
    tick(); rvalid = 0; settle();
    chk("t5_perr", perr, 1);
    chk("t5_busy", busy, 0);
    tick(); settle();
    chk("t5_sticky", perr, 1);
    rst_n = 0; settle();
    chk("t5_rst", perr, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
